sdio_data_block_ctrl: RTL and testbench
=======================================

// Module: sdio_data_block_ctrl
// PURPOSE
//  Sequences sdio_data_phy for one CMD53 data phase, byte or block mode.
//  Splits a transfer into per-block phy activations and inserts inter-block gaps.
//  Collects the per-block CRC result and reports done, abort and error status.
//  Sits between the CMD53 decoder / function layer and sdio_data_phy.
// PARAMETERS
//  GAP_CYCLES      2       clk cycles o_phy_activate is held low between blocks (min 1)
//  TIMEOUT_CYCLES  65535   per-block limit in clk cycles (only with SDIO_DATA_TIMEOUT_EN)
// PORTS
//  clk               in   1   system clock, single clock domain
//  rst               in   1   synchronous reset, active-high
//  i_start           in   1   1-cycle pulse: begin transfer; sampled only in IDLE
//  i_abort           in   1   level/pulse: cancel transfer (CMD52 abort / IO reset)
//  i_write_flag      in   1   1 = host->device (write), 0 = device->host (read)
//  i_block_mode      in   1   1 = block mode, 0 = byte mode
//  i_block_size      in   12  bytes per block; 0 = 2048
//  i_count           in   9   block mode: block count, 0 = infinite; byte mode: bytes, 0 = 512
//  o_busy            out  1   transfer in progress
//  o_done            out  1   1-cycle pulse at end of transfer (normal, abort, error)
//  o_crc_err         out  1   sticky until next start: write block failed CRC
//  o_aborted         out  1   sticky until next start: transfer ended by abort/timeout
//  o_timeout         out  1   sticky until next start: block timeout (0 without macro)
//  o_blocks_done     out  9   blocks completed with good status, modulo 512
//  o_phy_activate    out  1   to phy i_activate
//  o_phy_write_flag  out  1   to phy i_write_flag, latched at start
//  o_phy_data_count  out  13  to phy i_data_count, byte count of current block
//  i_phy_done        in   1   1-cycle pulse: phy reached FINISHED for current block
//  i_phy_crc_good    in   1   phy o_data_crc_good, valid in the i_phy_done cycle
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. A reset mid-transfer drops o_phy_activate
//   at the next edge. No o_done is emitted for a transfer killed by reset.
//  States: IDLE, SETUP, ACTIVE, GAP, FINISH.
//  - IDLE: on i_start, latch i_write_flag, i_block_mode, i_block_size and i_count.
//    Clear all sticky flags and o_blocks_done, set o_busy, go to SETUP.
//  - SETUP (1 cycle): drive o_phy_data_count.
//    Block mode: block_size, with 0 mapped to 2048. Byte mode: i_count, with 0 mapped to 512.
//    Go to ACTIVE.
//  - ACTIVE: o_phy_activate=1, wait for i_phy_done. On i_phy_done, drop activate.
//    If write and !i_phy_crc_good: set o_crc_err, go to FINISH.
//    Otherwise increment o_blocks_done (byte mode counts as 1 block).
//    If it was the last block, go to FINISH; else go to GAP.
//    Read direction ignores i_phy_crc_good.
//  - GAP: activate low for GAP_CYCLES, then go to ACTIVE (phy must see IDLE).
//  - FINISH (1 cycle): o_done=1, o_busy=0 at the next edge, go to IDLE.
//  Last block: remaining counter reaches 0. Infinite mode (block, count 0) never
//   ends except by abort or timeout. o_blocks_done wraps 511->0 without error.
//  Abort: i_abort in any non-IDLE state -> activate 0 next edge, o_aborted=1, go to FINISH.
//   Abort has priority over a simultaneous i_phy_done; that block is not counted.
//   i_abort in IDLE is ignored. i_start while busy is ignored.
//  i_start together with i_abort in IDLE: start is ignored.
//  Latency: i_start at edge N -> o_busy=1 after N. o_phy_activate=1 after N+2.
//   Final i_phy_done at edge M -> o_done high in the cycle after M.
// CONFIGURATION
//  SDIO_DATA_TIMEOUT_EN defined:
//   - Counter cleared on entering ACTIVE.
//   - At TIMEOUT_CYCLES without i_phy_done: set o_timeout and o_aborted,
//     drop activate, go to FINISH.
//  SDIO_DATA_TIMEOUT_EN undefined:
//   - No counter logic; o_timeout tied 0; ACTIVE waits indefinitely.
// TESTING
//  1 byte-mode read, i_count=4: start -> activate at +2, data_count=4;
//    phy_done -> o_done, blocks_done=1, no flags set.
//  2 block-mode write, size=64, count=3, all CRC good:
//    3 activations, each separated by >=2 low cycles; done with blocks_done=3.
//  3 block write, count=3, crc bad on block 2: crc_err=1, blocks_done=1,
//    done pulse, no 3rd activation.
//  4 infinite block read (count=0): run 600 blocks, blocks_done=88 (wrap);
//    abort -> activate low next cycle, aborted=1, done pulse.
//  5 abort in same cycle as phy_done: aborted=1, block not counted.
//    Follow with start in IDLE while busy ignored.
//  6 (macro on, TIMEOUT_CYCLES=16) phy_done withheld:
//    timeout=aborted=1 at cycle 16 of ACTIVE; size=0 maps to data_count=2048.

Source files
------------

// File: rtl/sdio_data_block_ctrl.sv
// Sequences sdio_data_phy through one CMD53 data phase (byte or block mode); block timeout under SDIO_DATA_TIMEOUT_EN.
// Latency: start -> busy +1, phy activate +2; final phy done -> o_done +1. No backpressure: phy paces blocks via i_phy_done.
module sdio_data_block_ctrl #(
  parameter int unsigned GAP_CYCLES = 2
`ifdef SDIO_DATA_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_write_flag,
  input  logic        i_block_mode,
  input  logic [11:0] i_block_size,
  input  logic [8:0]  i_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_err,
  output logic        o_aborted,
  output logic        o_timeout,
  output logic [8:0]  o_blocks_done,
  output logic        o_phy_activate,
  output logic        o_phy_write_flag,
  output logic [12:0] o_phy_data_count,
  input  logic        i_phy_done,
  input  logic        i_phy_crc_good
);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, GAP, FINISH} state_t;

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t          state;
  logic            blk_mode;
  logic            infinite;
  logic [11:0]     blk_size;
  logic [8:0]      remaining;
  logic [GW-1:0]   gap_cnt;
  logic [12:0]     setup_count;
  logic            last_block;

`ifdef SDIO_DATA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    setup_count = 13'd0;
    if (blk_mode)
      setup_count = (blk_size == 12'd0) ? 13'd2048 : {1'b0, blk_size};
    else
      setup_count = (remaining == 9'd0) ? 13'd512 : {4'd0, remaining};
  end

  // Byte mode is always a single block; infinite block mode never runs out.
  assign last_block = !blk_mode || (!infinite && remaining == 9'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      blk_mode         <= 1'b0;
      infinite         <= 1'b0;
      blk_size         <= 12'd0;
      remaining        <= 9'd0;
      gap_cnt          <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_crc_err        <= 1'b0;
      o_aborted        <= 1'b0;
      o_blocks_done    <= 9'd0;
      o_phy_activate   <= 1'b0;
      o_phy_write_flag <= 1'b0;
      o_phy_data_count <= 13'd0;
`ifdef SDIO_DATA_TIMEOUT_EN
      tmo_cnt          <= '0;
      o_timeout        <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      if (i_abort && state != IDLE && state != FINISH) begin
        // Abort wins over a same-cycle phy done, so that block is not counted.
        o_phy_activate <= 1'b0;
        o_aborted      <= 1'b1;
        o_done         <= 1'b1;
        state          <= FINISH;
      end else begin
        case (state)
          IDLE: begin
            if (i_start && !i_abort) begin
              o_phy_write_flag <= i_write_flag;
              blk_mode         <= i_block_mode;
              blk_size         <= i_block_size;
              remaining        <= i_count;
              infinite         <= i_block_mode && (i_count == 9'd0);
              o_crc_err        <= 1'b0;
              o_aborted        <= 1'b0;
              o_blocks_done    <= 9'd0;
              o_busy           <= 1'b1;
`ifdef SDIO_DATA_TIMEOUT_EN
              o_timeout        <= 1'b0;
`endif
              state            <= SETUP;
            end
          end
          SETUP: begin
            o_phy_data_count <= setup_count;
`ifdef SDIO_DATA_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
            state            <= ACTIVE;
          end
          ACTIVE: begin
            if (o_phy_activate && i_phy_done) begin
              o_phy_activate <= 1'b0;
              if (o_phy_write_flag && !i_phy_crc_good) begin
                o_crc_err <= 1'b1;
                o_done    <= 1'b1;
                state     <= FINISH;
              end else begin
                o_blocks_done <= o_blocks_done + 9'd1;
                if (blk_mode && !infinite)
                  remaining <= remaining - 9'd1;
                if (last_block) begin
                  o_done <= 1'b1;
                  state  <= FINISH;
                end else begin
                  gap_cnt <= '0;
                  state   <= GAP;
                end
              end
            end else begin
`ifdef SDIO_DATA_TIMEOUT_EN
              if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                o_phy_activate <= 1'b0;
                o_timeout      <= 1'b1;
                o_aborted      <= 1'b1;
                o_done         <= 1'b1;
                state          <= FINISH;
              end else begin
                tmo_cnt        <= tmo_cnt + 1'b1;
                o_phy_activate <= 1'b1;
              end
`else
              o_phy_activate <= 1'b1;
`endif
            end
          end
          GAP: begin
            // Re-raise activate on the last gap edge so it is low exactly GAP_CYCLES cycles.
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              o_phy_activate <= 1'b1;
`ifdef SDIO_DATA_TIMEOUT_EN
              tmo_cnt        <= '0;
`endif
              state          <= ACTIVE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          FINISH: begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdio_data_block_ctrl.sv
// Directed bench for sdio_data_block_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_sdio_data_block_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, wr, blk;
  logic [11:0] bsize;
  logic [8:0]  cnt;
  logic        busy, done, crc_err, aborted, tmo;
  logic [8:0]  bdone;
  logic        act, pwr;
  logic [12:0] dcnt;
  logic        pdone, pcrc;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sdio_data_block_ctrl #(
    .GAP_CYCLES(2)
`ifdef SDIO_DATA_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_write_flag(wr), .i_block_mode(blk), .i_block_size(bsize), .i_count(cnt),
    .o_busy(busy), .o_done(done), .o_crc_err(crc_err), .o_aborted(aborted),
    .o_timeout(tmo), .o_blocks_done(bdone), .o_phy_activate(act),
    .o_phy_write_flag(pwr), .o_phy_data_count(dcnt),
    .i_phy_done(pdone), .i_phy_crc_good(pcrc)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic wait_act;
    for (int i = 0; i < 100 && !act; i++) step();
    vec++;
    if (act !== 1'b1) begin errs++; $display("FAIL act_wait: activate=%b want 1 within 100 cycles", act); end
  endtask

  task automatic start_xfer(input logic w, input logic b, input logic [11:0] s, input logic [8:0] c);
    wr = w; blk = b; bsize = s; cnt = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns on the falling edge right after the clock edge that sampled i_phy_done.
  task automatic phy_block(input logic crc);
    wait_act();
    step();
    pdone = 1'b1; pcrc = crc;
    step();
    pdone = 1'b0; pcrc = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step();
    vec++; if ({busy, done, crc_err, aborted, tmo, act, pwr} !== 7'b0) begin errs++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, crc_err, aborted, tmo, act, pwr}); end
    vec++; if (bdone !== 9'd0) begin errs++; $display("FAIL reset_blocks: got %0d want 0", bdone); end
    vec++; if (dcnt !== 13'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", dcnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_byte_read;
    start_xfer(1'b0, 1'b0, 12'd100, 9'd4);
    vec++; if ({busy, act} !== 2'b10) begin errs++; $display("FAIL byte_n1: busy,act=%b want 10", {busy, act}); end
    step();
    vec++; if (act !== 1'b0) begin errs++; $display("FAIL byte_n2_act: got %b want 0", act); end
    vec++; if (dcnt !== 13'd4) begin errs++; $display("FAIL byte_count: got %0d want 4", dcnt); end
    step();
    vec++; if (act !== 1'b1) begin errs++; $display("FAIL byte_act_n3: got %b want 1", act); end
    step();
    pdone = 1'b1;
    step();
    pdone = 1'b0;
    vec++; if ({done, act} !== 2'b10) begin errs++; $display("FAIL byte_done: done,act=%b want 10", {done, act}); end
    vec++; if (bdone !== 9'd1) begin errs++; $display("FAIL byte_blocks: got %0d want 1", bdone); end
    vec++; if ({crc_err, aborted, tmo, pwr} !== 4'b0) begin errs++; $display("FAIL byte_flags: got %b want 0000", {crc_err, aborted, tmo, pwr}); end
    step();
    vec++; if ({done, busy} !== 2'b00) begin errs++; $display("FAIL byte_idle: done,busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_block_write;
    int lows;
    int seen;
    start_xfer(1'b1, 1'b1, 12'd64, 9'd3);
    for (int b = 0; b < 3; b++) begin
      phy_block(1'b1);
      vec++; if (dcnt !== 13'd64) begin errs++; $display("FAIL wr_count%0d: got %0d want 64", b, dcnt); end
      if (b < 2) begin
        vec++; if (done !== 1'b0) begin errs++; $display("FAIL wr_early_done%0d: got %b want 0", b, done); end
        lows = 0;
        while (!act && lows < 20) begin lows++; step(); end
        vec++; if (lows != 2) begin errs++; $display("FAIL wr_gap%0d: low cycles %0d want 2", b, lows); end
      end
    end
    vec++; if ({done, pwr, crc_err} !== 3'b110) begin errs++; $display("FAIL wr_done: done,wflag,crc=%b want 110", {done, pwr, crc_err}); end
    vec++; if (bdone !== 9'd3) begin errs++; $display("FAIL wr_blocks: got %0d want 3", bdone); end
    seen = 0;
    repeat (10) begin step(); if (act) seen++; end
    vec++; if (seen != 0 || busy !== 1'b0) begin errs++; $display("FAIL wr_after: extra activate cycles %0d busy %b want 0 0", seen, busy); end
  endtask

  task automatic test_crc_err;
    int seen;
    start_xfer(1'b1, 1'b1, 12'd32, 9'd3);
    phy_block(1'b1);
    phy_block(1'b0);
    vec++; if ({done, crc_err, aborted} !== 3'b110) begin errs++; $display("FAIL crc_flags: done,crc,abort=%b want 110", {done, crc_err, aborted}); end
    vec++; if (bdone !== 9'd1) begin errs++; $display("FAIL crc_blocks: got %0d want 1", bdone); end
    seen = 0;
    repeat (10) begin step(); if (act) seen++; end
    vec++; if (seen != 0 || busy !== 1'b0 || crc_err !== 1'b1) begin errs++; $display("FAIL crc_after: activates %0d busy %b crc %b want 0 0 1", seen, busy, crc_err); end
  endtask

  task automatic test_infinite;
    int early;
    start_xfer(1'b0, 1'b1, 12'd16, 9'd0);
    early = 0;
    for (int b = 0; b < 600; b++) begin
      phy_block(1'b0);
      if (done) early++;
    end
    vec++; if (early != 0) begin errs++; $display("FAIL inf_no_done: done pulses %0d want 0", early); end
    vec++; if (bdone !== 9'd88) begin errs++; $display("FAIL inf_wrap: got %0d want 88", bdone); end
    wait_act();
    abort = 1'b1;
    step();
    abort = 1'b0;
    vec++; if ({act, aborted, done} !== 3'b011) begin errs++; $display("FAIL inf_abort: act,abort,done=%b want 011", {act, aborted, done}); end
    vec++; if (bdone !== 9'd88) begin errs++; $display("FAIL inf_abort_blocks: got %0d want 88", bdone); end
    step();
    vec++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL inf_idle: busy,done=%b want 00", {busy, done}); end
  endtask

  task automatic test_abort_with_done;
    start_xfer(1'b0, 1'b1, 12'd8, 9'd3);
    phy_block(1'b1);
    wait_act();
    step();
    pdone = 1'b1; abort = 1'b1;
    step();
    pdone = 1'b0; abort = 1'b0;
    vec++; if ({aborted, done} !== 2'b11) begin errs++; $display("FAIL ab_flags: abort,done=%b want 11", {aborted, done}); end
    vec++; if (bdone !== 9'd1) begin errs++; $display("FAIL ab_blocks: got %0d want 1", bdone); end
    step();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ab_idle: busy=%b want 0", busy); end
    start_xfer(1'b0, 1'b0, 12'd0, 9'd2);
    vec++; if (aborted !== 1'b0) begin errs++; $display("FAIL ab_sticky_clear: got %b want 0", aborted); end
    wait_act();
    cnt = 9'd7; start = 1'b1;
    step();
    start = 1'b0;
    vec++; if ({busy, dcnt} !== {1'b1, 13'd2}) begin errs++; $display("FAIL busy_start: busy %b count %0d want 1 2", busy, dcnt); end
    pdone = 1'b1;
    step();
    pdone = 1'b0;
    vec++; if ({done, bdone} !== {1'b1, 9'd1}) begin errs++; $display("FAIL busy_done: done %b blocks %0d want 1 1", done, bdone); end
    step(); step();
    vec++; if ({busy, act} !== 2'b00) begin errs++; $display("FAIL busy_restart: busy,act=%b want 00", {busy, act}); end
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    step();
    vec++; if ({busy, act} !== 2'b00) begin errs++; $display("FAIL start_abort_idle: busy,act=%b want 00", {busy, act}); end
  endtask

  task automatic test_boundary;
    start_xfer(1'b0, 1'b1, 12'd0, 9'd1);
    step();
    vec++; if (dcnt !== 13'd2048) begin errs++; $display("FAIL size0: got %0d want 2048", dcnt); end
    phy_block(1'b1);
    vec++; if ({done, bdone} !== {1'b1, 9'd1}) begin errs++; $display("FAIL size0_done: done %b blocks %0d want 1 1", done, bdone); end
    step();
    start_xfer(1'b1, 1'b0, 12'd50, 9'd0);
    step();
    vec++; if (dcnt !== 13'd512) begin errs++; $display("FAIL bytes0: got %0d want 512", dcnt); end
    phy_block(1'b1);
    vec++; if ({done, bdone, crc_err} !== {1'b1, 9'd1, 1'b0}) begin errs++; $display("FAIL bytes0_done: done %b blocks %0d crc %b want 1 1 0", done, bdone, crc_err); end
    step();
  endtask

  task automatic test_reset_mid;
    start_xfer(1'b1, 1'b1, 12'd64, 9'd2);
    wait_act();
    rst = 1'b1;
    step();
    vec++; if ({act, busy, done} !== 3'b000) begin errs++; $display("FAIL rst_mid: act,busy,done=%b want 000", {act, busy, done}); end
    rst = 1'b0;
    step();
    vec++; if ({act, done} !== 2'b00) begin errs++; $display("FAIL rst_mid_after: act,done=%b want 00", {act, done}); end
  endtask

`ifdef SDIO_DATA_TIMEOUT_EN
  task automatic test_timeout;
    start_xfer(1'b0, 1'b1, 12'd0, 9'd1);
    step();
    vec++; if (dcnt !== 13'd2048) begin errs++; $display("FAIL tmo_size0: got %0d want 2048", dcnt); end
    repeat (15) step();
    vec++; if ({tmo, act} !== 2'b01) begin errs++; $display("FAIL tmo_early: timeout,act=%b want 01", {tmo, act}); end
    step();
    vec++; if ({tmo, aborted, done, act} !== 4'b1110) begin errs++; $display("FAIL tmo_fire: tmo,abort,done,act=%b want 1110", {tmo, aborted, done, act}); end
    step();
    vec++; if ({busy, tmo} !== 2'b01) begin errs++; $display("FAIL tmo_idle: busy,tmo=%b want 01", {busy, tmo}); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr = 1'b0; blk = 1'b0;
    bsize = 12'd0; cnt = 9'd0; pdone = 1'b0; pcrc = 1'b0;
    test_reset();
    test_byte_read();
    test_block_write();
    test_crc_err();
    test_infinite();
    test_abort_with_done();
    test_boundary();
    test_reset_mid();
`ifdef SDIO_DATA_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d vectors applied", vec);
    $fatal(1, "watchdog");
  end

endmodule
